hazard_forward_ctrl: RTL
========================

Name: hazard_forward_ctrl

Overview:
- Produces the select codes consumed by the EX-stage operand forwarding muxes (3-input, 2-bit select) and the stall/flush controls for the 5-stage pipeline.
- Keeps its own E/M/W shadow copies of register-use information, fed from the decode stage, so the datapath does not have to route rd/regwrite back to it.
- Also keeps saturating stall and flush event counters for performance debug.

Parameters:
REG_ADDR_WIDTH, 5, register index width
CNT_WIDTH, 16, width of stall/flush event counters

Ports:
clk  input  1  core clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
rs1_d  input  REG_ADDR_WIDTH  source reg 1 of instruction in D
rs2_d  input  REG_ADDR_WIDTH  source reg 2 of instruction in D
rd_d  input  REG_ADDR_WIDTH  destination reg of instruction in D
reg_write_d  input  1  D instruction writes rd
is_load_d  input  1  D instruction is a load (result from memory)
pc_src_e  input  1  branch/jump taken, resolved in EX
forward_a_e  output  2  select for EX operand A mux: 00 regfile, 01 WB result, 10 MEM ALU result
forward_b_e  output  2  same encoding, operand B
stall_f  output  1  hold PC
stall_d  output  1  hold IF/ID register
flush_d  output  1  clear IF/ID register
flush_e  output  1  clear ID/EX register
stall_count  output  CNT_WIDTH  load-use stall cycles since reset
flush_count  output  CNT_WIDTH  taken-branch flushes since reset

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous, active-high.
- Internal state:
  - E slot: rs1_e, rs2_e, rd_e, rw_e, ld_e.
  - M slot: rd_m, rw_m.
  - W slot: rd_w, rw_w.
  - Counters: stall_count, flush_count.
- Reset: every internal register and both counters are 0. While rst is high, all outputs are forced to 0, including the combinational outputs, regardless of inputs. The first non-reset cycle therefore sees an empty pipeline: no forwarding, no stall.
- Load-use detect (combinational):
  - lwstall = ld_e & (rd_e != 0) & ((rs1_d == rd_e) | (rs2_d == rd_e)).
- Forwarding (combinational, operand A shown; B identical using rs2_e):
  - If rs1_e != 0 & rw_m & rs1_e == rd_m, then 10.
  - Else if rs1_e != 0 & rw_w & rs1_e == rd_w, then 01.
  - Else 00.
  - M has priority over W when both match. Register x0 is never forwarded. Code 11 is never produced.
- Control outputs (combinational):
  - stall_f = stall_d = lwstall.
  - flush_d = pc_src_e.
  - flush_e = lwstall | pc_src_e.
- Shadow pipeline update each rising edge (rst low):
  - E slot: if flush_e, all E fields become 0 (bubble). Otherwise E takes rs1_d, rs2_d, rd_d, reg_write_d, is_load_d.
  - M and W slots: always advance, M <= E (rd, rw) and W <= M. They are never stalled.
  - A bubble therefore propagates as rw = 0 through M and W.
- Simultaneous lwstall and pc_src_e:
  - flush_e = 1, stall_f = stall_d = 1, flush_d = 1.
  - The datapath gives flush precedence over stall on IF/ID.
  - The stall counter increments; the flush counter increments.
- Counters:
  - stall_count += 1 on each cycle with lwstall.
  - flush_count += 1 on each cycle with pc_src_e.
  - Both saturate at all-ones; they do not wrap.
- Reset mid-operation: the next edge clears all slots and counters. In-flight forwarding matches are lost; this is correct because the datapath is also reset.
- Latency:
  - Forward selects reflect the current E/M/W contents with zero added delay.
  - An instruction presented on the D inputs affects the forward selects one cycle later (as E) and the load-use check while it is in E.

Test Plan:
- Back-to-back ALU dependency: D = add x5 (rd=5, rw=1); next cycle D = sub, rs1=5. In the following cycle, forward_a_e=10 and forward_b_e=00. One cycle later, with rs1_e matching only rd_w, the select is 01.
- Double hazard priority: rd=7 written by two consecutive instructions, then a consumer with rs2=7. The consumer in E shows forward_b_e=10 (M wins), never 01.
- x0 never forwarded: producer rd=0, rw=1, then consumer rs1=0. forward_a_e=00 throughout.
- Load-use stall:
  - D = lw x3 (is_load=1), then D = add rs1=3. One cycle with stall_f=stall_d=flush_e=1, stall_count 0 -> 1.
  - The next cycle with the same D inputs shows stall=0, and then forward_a_e=01 once the load reaches W.
- Taken branch: pc_src_e=1 for one cycle while D holds rd=9 rw=1. Response: flush_d=flush_e=1 and flush_count=1. No forwarding from rd=9 occurs in the next two cycles.
- Reset and saturation:
  - Assert rst mid-stream. All outputs are 0 during reset and both counters read 0 after it.
  - Preload by running 2^CNT_WIDTH+3 stall cycles (CNT_WIDTH=4 build): stall_count holds at 15.

Source files
------------

// File: rtl/hazard_forward_ctrl.sv
// Hazard unit: EX forward selects, load-use stall, branch flush,
// with private E/M/W register-use shadows and saturating event counters.
module hazard_forward_ctrl #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [REG_ADDR_WIDTH-1:0] rs1_d,
  input  logic [REG_ADDR_WIDTH-1:0] rs2_d,
  input  logic [REG_ADDR_WIDTH-1:0] rd_d,
  input  logic                      reg_write_d,
  input  logic                      is_load_d,
  input  logic                      pc_src_e,
  output logic [1:0]                forward_a_e,
  output logic [1:0]                forward_b_e,
  output logic                      stall_f,
  output logic                      stall_d,
  output logic                      flush_d,
  output logic                      flush_e,
  output logic [CNT_WIDTH-1:0]      stall_count,
  output logic [CNT_WIDTH-1:0]      flush_count
);

  localparam logic [REG_ADDR_WIDTH-1:0] X0      = '0;
  localparam logic [CNT_WIDTH-1:0]      CNT_MAX = '1;

  logic [REG_ADDR_WIDTH-1:0] r_rs1_e;
  logic [REG_ADDR_WIDTH-1:0] r_rs2_e;
  logic [REG_ADDR_WIDTH-1:0] r_rd_e;
  logic                      r_rw_e;
  logic                      r_ld_e;
  logic [REG_ADDR_WIDTH-1:0] r_rd_m;
  logic                      r_rw_m;
  logic [REG_ADDR_WIDTH-1:0] r_rd_w;
  logic                      r_rw_w;
  logic [CNT_WIDTH-1:0]      r_stall_cnt;
  logic [CNT_WIDTH-1:0]      r_flush_cnt;

  logic       w_lwstall;
  logic       w_flush_e;
  logic [1:0] w_fwd_a;
  logic [1:0] w_fwd_b;

  // MEM is younger than WB, so its match wins.
  function automatic logic [1:0] fwd_sel(
    input logic [REG_ADDR_WIDTH-1:0] rs
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (rs != X0 && r_rw_m && rs == r_rd_m) begin
      sel = 2'b10;
    end else if (rs != X0 && r_rw_w && rs == r_rd_w) begin
      sel = 2'b01;
    end
    return sel;
  endfunction

  always_comb begin
    w_lwstall = r_ld_e && (r_rd_e != X0) &&
                ((rs1_d == r_rd_e) || (rs2_d == r_rd_e));
    w_flush_e = w_lwstall || pc_src_e;
    w_fwd_a   = fwd_sel(r_rs1_e);
    w_fwd_b   = fwd_sel(r_rs2_e);
  end

  always_comb begin
    forward_a_e = 2'b00;
    forward_b_e = 2'b00;
    stall_f     = 1'b0;
    stall_d     = 1'b0;
    flush_d     = 1'b0;
    flush_e     = 1'b0;
    stall_count = '0;
    flush_count = '0;
    if (!rst) begin
      forward_a_e = w_fwd_a;
      forward_b_e = w_fwd_b;
      stall_f     = w_lwstall;
      stall_d     = w_lwstall;
      flush_d     = pc_src_e;
      flush_e     = w_flush_e;
      stall_count = r_stall_cnt;
      flush_count = r_flush_cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rs1_e     <= '0;
      r_rs2_e     <= '0;
      r_rd_e      <= '0;
      r_rw_e      <= 1'b0;
      r_ld_e      <= 1'b0;
      r_rd_m      <= '0;
      r_rw_m      <= 1'b0;
      r_rd_w      <= '0;
      r_rw_w      <= 1'b0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_flush_e) begin
        r_rs1_e <= '0;
        r_rs2_e <= '0;
        r_rd_e  <= '0;
        r_rw_e  <= 1'b0;
        r_ld_e  <= 1'b0;
      end else begin
        r_rs1_e <= rs1_d;
        r_rs2_e <= rs2_d;
        r_rd_e  <= rd_d;
        r_rw_e  <= reg_write_d;
        r_ld_e  <= is_load_d;
      end
      r_rd_m <= r_rd_e;
      r_rw_m <= r_rw_e;
      r_rd_w <= r_rd_m;
      r_rw_w <= r_rw_m;
      if (w_lwstall && r_stall_cnt != CNT_MAX) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
      if (pc_src_e && r_flush_cnt != CNT_MAX) begin
        r_flush_cnt <= r_flush_cnt + 1'b1;
      end
    end
  end

endmodule
